// File: rtl/i2s_tx_serializer.sv
// I2S Philips-format transmitter and clock master. Pops {L,R} frames from a FIFO and
// shifts them out MSB-first in 32-bit slots. A missing frame is replaced by silence.
module i2s_tx_serializer #(
    parameter int SAMPLE_W = 24,
    parameter int BCLK_DIV = 4,
    parameter int UCNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [2*SAMPLE_W-1:0] fifo_rdata,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    output logic                  bclk,
    output logic                  lrck,
    output logic                  sdata,
    output logic                  frame_start,
    output logic                  underrun,
    output logic [UCNT_W-1:0]     underrun_cnt
);
    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [5:0] BIT_PREFETCH = 6'd61;
    localparam logic [4:0] SLOT_LAST = 5'(SAMPLE_W);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CAPTURE, S_RUN} state_t;
    state_t state_q, state_d;

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               bclk_q, bclk_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [FRAME_W-1:0] hold_q, hold_d;
    logic               sdata_q, sdata_d;
    logic               frame_start_q, frame_start_d;
    logic               prefetch_q, prefetch_d;
    logic               capture_q, capture_d;
    logic               last_q, last_d;
    logic [UCNT_W-1:0]  ucnt_q, ucnt_d;

    logic fall_edge;
    logic wrap;
    logic fetch_slot;
    logic enter_run;
    logic capture_now;

    // Bit p of a slot carries sample bit SAMPLE_W-p; slot bit 0 and the pad bits are zero.
    function automatic logic slot_bit(input logic [5:0] b, input logic [FRAME_W-1:0] fr);
        logic [SAMPLE_W-1:0] chan;
        logic [SAMPLE_W-1:0] shifted;
        logic [4:0]          p;
        logic [5:0]          shamt;
        p       = b[4:0];
        chan    = b[5] ? fr[SAMPLE_W-1:0] : fr[FRAME_W-1:SAMPLE_W];
        shamt   = 6'(SAMPLE_W) - {1'b0, p};
        shifted = chan >> shamt;
        return (p != 5'd0 && p <= SLOT_LAST) ? shifted[0] : 1'b0;
    endfunction

    assign fall_edge = (state_q == S_RUN) && bclk_q && (div_cnt_q == DIV_LAST);
    assign wrap      = fall_edge && (bit_cnt_q == 6'd63);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (enable) state_d = S_FETCH;
            S_FETCH:   state_d = fifo_empty ? S_RUN : S_CAPTURE;
            S_CAPTURE: state_d = S_RUN;
            S_RUN:     if (wrap && last_q) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_slot  = (state_q == S_FETCH) || prefetch_q;
        fifo_ren    = fetch_slot && !fifo_empty;
        underrun    = fetch_slot && fifo_empty;
        enter_run   = ((state_q == S_FETCH) && fifo_empty) || (state_q == S_CAPTURE);
        capture_now = (state_q == S_CAPTURE) || capture_q;
    end

    always_comb begin
        div_cnt_d     = div_cnt_q;
        bclk_d        = bclk_q;
        bit_cnt_d     = bit_cnt_q;
        frame_d       = frame_q;
        hold_d        = hold_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        prefetch_d    = 1'b0;
        capture_d     = prefetch_q && !fifo_empty;
        last_d        = last_q;
        ucnt_d        = ucnt_q;

        if (underrun) begin
            hold_d = '0;
            if (ucnt_q != '1) ucnt_d = ucnt_q + UCNT_W'(1);
        end else if (capture_now) begin
            hold_d = fifo_rdata;
        end

        if (enter_run) begin
            div_cnt_d     = '0;
            bclk_d        = 1'b0;
            bit_cnt_d     = '0;
            frame_d       = hold_d;
            frame_start_d = 1'b1;
            sdata_d       = 1'b0;
            last_d        = 1'b0;
        end else if (state_q == S_RUN) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                bclk_d    = ~bclk_q;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
            if (fall_edge) begin
                bit_cnt_d = bit_cnt_q + 6'd1;
                // enable is only looked at here, two bits before the frame ends
                if (bit_cnt_q == BIT_PREFETCH) begin
                    prefetch_d = enable;
                    last_d     = !enable;
                end
                if (wrap && !last_q) begin
                    frame_d       = hold_q;
                    frame_start_d = 1'b1;
                end
                sdata_d = (wrap && last_q) ? 1'b0 : slot_bit(bit_cnt_d, frame_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            bclk_q        <= 1'b0;
            bit_cnt_q     <= '0;
            frame_q       <= '0;
            hold_q        <= '0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            prefetch_q    <= 1'b0;
            capture_q     <= 1'b0;
            last_q        <= 1'b0;
            ucnt_q        <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bclk_q        <= bclk_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_q       <= frame_d;
            hold_q        <= hold_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            prefetch_q    <= prefetch_d;
            capture_q     <= capture_d;
            last_q        <= last_d;
            ucnt_q        <= ucnt_d;
        end
    end

    assign bclk         = bclk_q;
    assign lrck         = bit_cnt_q[5];
    assign sdata        = sdata_q;
    assign frame_start  = frame_start_q;
    assign underrun_cnt = ucnt_q;
endmodule
